// File: rtl/heap_pq_param.sv
// Binary-heap priority queue with configurable key/value width, capacity and ordering.
// Sift-up/sift-down run one heap level per cycle behind a busy flag.
module heap_pq_param #(
  parameter int KEY_W      = 8,
  parameter int VAL_W      = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int MAX_HEAP   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq,
  input  logic                  deq,
  input  logic [KEY_W-1:0]      kvi_key,
  input  logic [VAL_W-1:0]      kvi_val,
  output logic [KEY_W-1:0]      kvo_key,
  output logic [VAL_W-1:0]      kvo_val,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic [DEPTH_LOG2-1:0] count
);

  localparam int CAP = (1 << DEPTH_LOG2) - 1;
  localparam int IW  = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DN} state_t;

  // NOTE: the heap array is plain storage with no reset; count alone defines which entries are live.
  logic [KEY_W-1:0] heap_key [1:CAP];
  logic [VAL_W-1:0] heap_val [1:CAP];

  state_t                state;
  logic [IW-1:0]         cursor;
  logic [DEPTH_LOG2-1:0] cnt;

  logic [IW-1:0] cnt_ext;
  logic [IW-1:0] tail;
  logic [IW-1:0] parent;
  logic [IW-1:0] lc;
  logic [IW-1:0] rc;
  logic [IW-1:0] best;
  logic [IW:0]   best_lc;
  logic          lc_ok;
  logic          rc_ok;
  logic          up_swap;
  logic          dn_swap;

  function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
    return (MAX_HEAP != 0) ? (a > b) : (a < b);
  endfunction

  always_comb begin
    cnt_ext = {1'b0, cnt};
    tail    = cnt_ext + IW'(1);
    parent  = cursor >> 1;
    lc      = {cursor[IW-2:0], 1'b0};
    rc      = {cursor[IW-2:0], 1'b1};
    lc_ok   = (lc <= cnt_ext);
    rc_ok   = (rc <= cnt_ext);
    // Left child wins ties, so the right child is taken only when strictly better.
    best    = (rc_ok && better(heap_key[rc], heap_key[lc])) ? rc : lc;
    best_lc = {best, 1'b0};
    up_swap = (cursor != IW'(1)) && better(heap_key[cursor], heap_key[parent]);
    dn_swap = lc_ok && better(heap_key[best], heap_key[cursor]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      cursor <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enq && deq && !empty) begin
            heap_key[1] <= kvi_key;
            heap_val[1] <= kvi_val;
            cursor      <= IW'(1);
            if (cnt_ext > IW'(1)) state <= SIFT_DN;
          end else if (enq && !full) begin
            heap_key[tail] <= kvi_key;
            heap_val[tail] <= kvi_val;
            cnt            <= cnt + DEPTH_LOG2'(1);
            cursor         <= tail;
            if (cnt != '0) state <= SIFT_UP;
          end else if (deq && !enq && !empty) begin
            heap_key[1] <= heap_key[cnt_ext];
            heap_val[1] <= heap_val[cnt_ext];
            cnt         <= cnt - DEPTH_LOG2'(1);
            cursor      <= IW'(1);
            if (cnt_ext > IW'(2)) state <= SIFT_DN;
          end
        end
        SIFT_UP: begin
          if (up_swap) begin
            // NOTE: non-blocking assignments make this a true swap; both sides read the pre-edge values.
            heap_key[cursor] <= heap_key[parent];
            heap_val[cursor] <= heap_val[parent];
            heap_key[parent] <= heap_key[cursor];
            heap_val[parent] <= heap_val[cursor];
            cursor           <= parent;
            // Reaching the root needs no further compare, which keeps the worst case at DEPTH_LOG2-1 cycles.
            if (parent == IW'(1)) state <= IDLE;
          end else begin
            state <= IDLE;
          end
        end
        SIFT_DN: begin
          if (dn_swap) begin
            heap_key[cursor] <= heap_key[best];
            heap_val[cursor] <= heap_val[best];
            heap_key[best]   <= heap_key[cursor];
            heap_val[best]   <= heap_val[cursor];
            cursor           <= best;
            if (best_lc > {1'b0, cnt_ext}) state <= IDLE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign count   = cnt;
  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_LOG2'(CAP));
  assign busy    = (state != IDLE);
  assign kvo_key = empty ? '0 : heap_key[1];
  assign kvo_val = empty ? '0 : heap_val[1];

endmodule

// File: tb/tb_heap_pq_param.sv
// Directed bench for heap_pq_param: a min-heap and a max-heap instance share one stimulus stream.
module tb_heap_pq_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enq = 1'b0;
  logic       deq = 1'b0;
  logic [7:0] kvi_key = '0;
  logic [7:0] kvi_val = '0;

  logic [7:0] key_a, val_a, key_b, val_b;
  logic       full_a, empty_a, busy_a, full_b, empty_b, busy_b;
  logic [3:0] count_a, count_b;

  int checks   = 0;
  int failures = 0;

  heap_pq_param #(.KEY_W(8), .VAL_W(8), .DEPTH_LOG2(4), .MAX_HEAP(0)) u_min (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi_key(kvi_key), .kvi_val(kvi_val),
    .kvo_key(key_a), .kvo_val(val_a), .full(full_a), .empty(empty_a), .busy(busy_a),
    .count(count_a)
  );

  heap_pq_param #(.KEY_W(8), .VAL_W(8), .DEPTH_LOG2(4), .MAX_HEAP(1)) u_max (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi_key(kvi_key), .kvi_val(kvi_val),
    .kvo_key(key_b), .kvo_val(val_b), .full(full_b), .empty(empty_b), .busy(busy_b),
    .count(count_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       e;
    logic       d;
    logic [7:0] k;
    logic [7:0] v;
    logic [3:0] c;
    logic [7:0] ek;
    logic [7:0] ev;
    logic       emp;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic e, input logic d, input logic [7:0] k, input logic [7:0] v,
                              input logic [3:0] c, input logic [7:0] ek, input logic [7:0] ev,
                              input logic emp);
    vec_t r;
    r.e = e; r.d = d; r.k = k; r.v = v; r.c = c; r.ek = ek; r.ev = ev; r.emp = emp;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Returns the number of cycles the min-heap instance spent busy.
  task automatic wait_idle(output int n);
    int guard;
    n = 0;
    guard = 0;
    while ((busy_a || busy_b) && guard < 20) begin
      if (busy_a) n++;
      @(posedge clk);
      #1;
      guard++;
    end
    check("idle_within_bound", {30'd0, busy_a, busy_b}, 0);
  endtask

  task automatic do_op(input logic e, input logic d, input logic [7:0] k, input logic [7:0] v,
                       output int n);
    enq = e; deq = d; kvi_key = k; kvi_val = v;
    @(posedge clk);
    #1;
    enq = 1'b0; deq = 1'b0;
    wait_idle(n);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int maxb;
    logic [3:0] mask;

    // Reset state
    do_reset();
    check("rst_count", count_a, 0);
    check("rst_empty", empty_a, 1);
    check("rst_full",  full_a,  0);
    check("rst_busy",  busy_a,  0);
    check("rst_key",   key_a,   0);
    check("rst_val",   val_a,   0);
    check("rst_max_key", key_b, 0);

    // Min-heap operation table: {enq, deq, key, val, exp count, exp top key, exp top val, exp empty}
    tbl[0]  = mk(0, 1,  0,   0, 0, 0,   0, 1);
    tbl[1]  = mk(1, 0,  9, 109, 1, 9, 109, 0);
    tbl[2]  = mk(1, 0,  4, 104, 2, 4, 104, 0);
    tbl[3]  = mk(1, 0,  7, 107, 3, 4, 104, 0);
    tbl[4]  = mk(1, 0,  1, 101, 4, 1, 101, 0);
    tbl[5]  = mk(0, 1,  0,   0, 3, 4, 104, 0);
    tbl[6]  = mk(0, 1,  0,   0, 2, 7, 107, 0);
    tbl[7]  = mk(0, 1,  0,   0, 1, 9, 109, 0);
    tbl[8]  = mk(0, 1,  0,   0, 0, 0,   0, 1);
    tbl[9]  = mk(1, 1,  2, 102, 1, 2, 102, 0);
    tbl[10] = mk(1, 0,  5, 105, 2, 2, 102, 0);
    tbl[11] = mk(1, 0,  8, 108, 3, 2, 102, 0);
    tbl[12] = mk(1, 1,  6, 106, 3, 5, 105, 0);
    tbl[13] = mk(0, 1,  0,   0, 2, 6, 106, 0);
    tbl[14] = mk(0, 1,  0,   0, 1, 8, 108, 0);
    tbl[15] = mk(0, 1,  0,   0, 0, 0,   0, 1);

    for (int i = 0; i < 16; i++) begin
      do_op(tbl[i].e, tbl[i].d, tbl[i].k, tbl[i].v, n);
      check($sformatf("row%0d_count", i), count_a, tbl[i].c);
      check($sformatf("row%0d_key",   i), key_a,   tbl[i].ek);
      check($sformatf("row%0d_val",   i), val_a,   tbl[i].ev);
      check($sformatf("row%0d_empty", i), empty_a, tbl[i].emp);
      check($sformatf("row%0d_full",  i), full_a,  0);
    end

    // Fill to capacity with descending keys; key 8 and key 1 each climb three levels.
    do_reset();
    maxb = 0;
    for (int k = 15; k >= 1; k--) begin
      do_op(1'b1, 1'b0, 8'(k), 8'(k + 100), n);
      if (n > maxb) maxb = n;
    end
    check("fill_full",     full_a,  1);
    check("fill_count",    count_a, 15);
    check("fill_key",      key_a,   1);
    check("fill_max_busy", maxb,    3);
    do_op(1'b1, 1'b0, 8'd0, 8'd200, n);
    check("over_count", count_a, 15);
    check("over_key",   key_a,   1);
    check("over_val",   val_a,   101);
    check("over_full",  full_a,  1);
    do_op(1'b0, 1'b1, 8'd0, 8'd0, n);
    check("full_deq_key",   key_a,   2);
    check("full_deq_count", count_a, 14);

    // Reset asserted on the first busy cycle of a sift-up
    do_reset();
    for (int k = 1; k <= 7; k++) do_op(1'b1, 1'b0, 8'(k * 10), 8'(k), n);
    check("pre_midrst_count", count_a, 7);
    enq = 1'b1; kvi_key = 8'd0; kvi_val = 8'd99;
    @(posedge clk);
    #1;
    enq = 1'b0;
    check("midrst_busy", busy_a, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_count", count_a, 0);
    check("midrst_busy_clr", busy_a, 0);
    check("midrst_empty", empty_a, 1);
    check("midrst_key", key_a, 0);
    rst = 1'b1;
    do_op(1'b1, 1'b0, 8'd42, 8'd43, n);
    check("post_midrst_count", count_a, 1);
    check("post_midrst_key",   key_a,   42);

    // Max-heap ordering
    do_reset();
    do_op(1'b1, 1'b0, 8'd3,   8'd103, n);
    do_op(1'b1, 1'b0, 8'd200, 8'd44,  n);
    do_op(1'b1, 1'b0, 8'd50,  8'd150, n);
    check("max_count", count_b, 3);
    check("max_top0",  key_b,   200);
    check("max_val0",  val_b,   44);
    check("min_top_same_stream", key_a, 3);
    do_op(1'b0, 1'b1, 8'd0, 8'd0, n);
    check("max_top1", key_b, 50);
    do_op(1'b0, 1'b1, 8'd0, 8'd0, n);
    check("max_top2", key_b, 3);
    check("max_val2", val_b, 103);
    do_op(1'b0, 1'b1, 8'd0, 8'd0, n);
    check("max_empty", empty_b, 1);

    // Equal keys drain with every payload preserved
    do_reset();
    for (int k = 1; k <= 3; k++) do_op(1'b1, 1'b0, 8'd5, 8'(k), n);
    mask = '0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("eq_key%0d", k), key_a, 5);
      if (val_a < 8'd4) mask[val_a[1:0]] = 1'b1;
      do_op(1'b0, 1'b1, 8'd0, 8'd0, n);
    end
    check("eq_vals", mask, 4'b1110);
    check("eq_empty", empty_a, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
